// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one DATA_WIDTH-bit MSB-first word per start request,
// with a runtime-programmable SCLK half-period (clk_div, 0 treated as 1).
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n,
  output logic [2:0]            state_dbg
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  // Handshake: start is accepted on any rising clk edge where start=1 and
  // busy=0; done pulses for one cycle when rx_data holds the new word.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  half_q, half_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [BW-1:0]         bit_inc;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  phase_end;

  assign phase_end = (cnt_q == half_q - DIV_WIDTH'(1));
  assign bit_inc   = bit_q + BW'(1);

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = phase_end ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          half_d  = (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;
          tx_sr_d = tx_data;
          rx_sr_d = '0;
          bit_d   = '0;
          mosi_d  = tx_data[DATA_WIDTH-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (phase_end) begin
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], miso};
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          sclk_d  = 1'b0;
          bit_d   = bit_inc;
          state_d = SHIFT_LO;
          if (bit_inc < BW'(DATA_WIDTH)) begin
            mosi_d  = tx_sr_q[DATA_WIDTH-2];
            tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      SHIFT_LO: begin
        // After the last bit this low phase is the trailing half of the
        // final SCLK period; HOLD then adds one more half-period before cs_n.
        if (phase_end) begin
          if (bit_q == BW'(DATA_WIDTH)) begin
            state_d = HOLD;
          end else begin
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], miso};
            state_d = SHIFT_HI;
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          bit_d     = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      half_q    <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs_n      = cs_n_q;
  assign state_dbg = state_q;

endmodule
